// File: rtl/attn_score_mac.sv
// Serial q/k dot-product engine: accumulate NFEAT products, scale, saturate,
// and queue scores in a small circular FIFO behind a vld/rdy master port.
module attn_score_mac #(
  parameter int DW         = 8,
  parameter int NFEAT      = 4,
  parameter int SHIFT      = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] s_data,
  input  logic          s_vld,
  output logic          s_rdy,
  output logic [DW-1:0] m_data,
  output logic          m_sat,
  output logic          m_vld,
  input  logic          m_rdy
);

  localparam int ACCW = 2*DW + $clog2(NFEAT) + 1;
  localparam int CW   = (NFEAT > 1) ? $clog2(NFEAT) : 1;
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int SH   = DW - 1 + SHIFT;

  localparam logic [1:0] ST_GET_Q  = 2'd0;
  localparam logic [1:0] ST_GET_K  = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

  localparam logic [CW-1:0] LAST  = CW'(NFEAT - 1);
  localparam logic [PW:0]   DEPTH = (PW+1)'(FIFO_DEPTH);

  localparam logic signed [ACCW-1:0] MAXV =
    $signed({{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}});
  localparam logic signed [ACCW-1:0] MINV =
    $signed({{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}});

  logic [1:0]             state_q, state_d;
  logic [DW-1:0]          qv_q, qv_d;
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [PW-1:0]          wr_q, wr_d;
  logic [PW-1:0]          rd_q, rd_d;
  logic [PW:0]            count_q, count_d;
  logic [DW:0]            mem_q [FIFO_DEPTH];
  logic [DW:0]            mem_d [FIFO_DEPTH];

  logic                   xfer, full, push, pop;
  logic signed [2*DW-1:0] qx, kx, prod;
  logic signed [ACCW-1:0] t;
  logic [DW-1:0]          score;
  logic                   sat;
  logic [DW:0]            head;

  assign s_rdy = (state_q != ST_FINISH);
  assign xfer  = s_vld & s_rdy;
  assign full  = (count_q == DEPTH);
  assign m_vld = (count_q != '0);
  assign pop   = m_vld & m_rdy;
  assign push  = (state_q == ST_FINISH) & (~full | pop);

  assign qx   = {{DW{qv_q[DW-1]}}, qv_q};
  assign kx   = {{DW{s_data[DW-1]}}, s_data};
  assign prod = qx * kx;

  // floor-rounded scale, then clamp to the DW-bit signed range
  assign t = acc_q >>> SH;

  always_comb begin
    score = t[DW-1:0];
    sat   = 1'b0;
    unique case (1'b1)
      (t > MAXV): begin
        score = MAXV[DW-1:0];
        sat   = 1'b1;
      end
      (t < MINV): begin
        score = MINV[DW-1:0];
        sat   = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    qv_d    = qv_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_GET_Q: begin
        if (xfer) begin
          qv_d    = s_data;
          state_d = ST_GET_K;
        end
      end
      ST_GET_K: begin
        if (xfer) begin
          acc_d = acc_q
            + {{(ACCW-2*DW){prod[2*DW-1]}}, prod};
          cnt_d = cnt_q + 1'b1;
          state_d = (cnt_q == LAST) ? ST_FINISH : ST_GET_Q;
        end
      end
      ST_FINISH: begin
        if (push) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_GET_Q;
        end
      end
      default: state_d = ST_GET_Q;
    endcase
  end

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    count_d = count_q;
    if (push) begin
      mem_d[wr_q] = {sat, score};
      wr_d = wr_q + 1'b1;
    end
    if (pop) rd_d = rd_q + 1'b1;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  assign head   = mem_q[rd_q];
  assign m_data = m_vld ? head[DW-1:0] : '0;
  assign m_sat  = m_vld & head[DW];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_GET_Q;
      qv_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      qv_q    <= qv_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: tb/tb_attn_score_mac.sv
// Scoreboard bench for attn_score_mac: expected {sat,score} queued at
// stimulus time, compared whenever the DUT presents a head entry.
module tb_attn_score_mac;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] s_data = '0;
  logic       s_vld = 1'b0;
  logic       s_rdy;
  logic [7:0] m_data;
  logic       m_sat;
  logic       m_vld;
  logic       m_rdy = 1'b1;

  int nchecks = 0;
  int nerr = 0;
  logic [8:0] sb [$];
  bit done;

  always #5 clk = ~clk;

  attn_score_mac #(
    .DW(8), .NFEAT(4), .SHIFT(1), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_data(s_data), .s_vld(s_vld), .s_rdy(s_rdy),
    .m_data(m_data), .m_sat(m_sat), .m_vld(m_vld), .m_rdy(m_rdy)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] model(input int acc);
    int t;
    logic [31:0] tv;
    t = (acc >= 0) ? acc / 256 : -((-acc + 255) / 256);
    tv = t;
    if (t > 127) return {1'b1, 8'h7F};
    if (t < -128) return {1'b1, 8'h80};
    return {1'b0, tv[7:0]};
  endfunction

  task automatic send_beat(input logic [7:0] d, input int gapmax);
    int n;
    bit ok;
    s_data = d;
    s_vld = 1'b1;
    n = 0;
    ok = 0;
    while (!ok && n < 1000) begin
      @(negedge clk);
      ok = s_rdy;
      @(posedge clk);
      n++;
    end
    #1;
    s_vld = 1'b0;
    if (!ok) chk("beat_tmo", 0, 1);
    if (gapmax > 0) begin
      repeat ($urandom_range(0, gapmax)) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic send_vec(input logic [7:0] qa [4],
                          input logic [7:0] ka [4],
                          input int gapmax);
    int acc, qi, ki;
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      qi = $signed(qa[i]);
      ki = $signed(ka[i]);
      acc += qi * ki;
    end
    sb.push_back(model(acc));
    for (int i = 0; i < 4; i++) begin
      send_beat(qa[i], gapmax);
      send_beat(ka[i], gapmax);
    end
  endtask

  task automatic send_uni(input logic [7:0] q, input logic [7:0] k);
    logic [7:0] qa [4];
    logic [7:0] ka [4];
    for (int i = 0; i < 4; i++) begin
      qa[i] = q;
      ka[i] = k;
    end
    send_vec(qa, ka, 0);
  endtask

  task automatic send_one(input logic [7:0] q, input logic [7:0] k);
    logic [7:0] qa [4];
    logic [7:0] ka [4];
    for (int i = 0; i < 4; i++) begin
      qa[i] = 8'h00;
      ka[i] = 8'h00;
    end
    qa[0] = q;
    ka[0] = k;
    send_vec(qa, ka, 0);
  endtask

  task automatic drain();
    int n;
    m_rdy = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    chk("drain_vld", m_vld, 0);
    chk("drain_sb", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && m_vld) begin
      if (sb.size() == 0) begin
        chk("sb_empty", 1, 0);
      end else begin
        chk(m_rdy ? "pop" : "hold", {m_sat, m_data}, sb[0]);
        if (m_rdy) void'(sb.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] qa [4];
    logic [7:0] ka [4];

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_srdy", s_rdy, 1);
    chk("rst_vld", m_vld, 0);
    chk("rst_data", m_data, 0);
    chk("rst_sat", m_sat, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    send_uni(8'h40, 8'h40);
    @(negedge clk);
    chk("fin_srdy", s_rdy, 0);
    chk("lat_vld0", m_vld, 0);
    @(negedge clk);
    chk("lat_vld1", m_vld, 1);
    chk("next_q_rdy", s_rdy, 1);
    @(posedge clk);
    #1;
    drain();

    send_uni(8'h7F, 8'h7F);
    send_uni(8'h80, 8'h7F);
    send_one(8'h01, 8'hFF);
    send_one(8'h01, 8'h01);
    drain();

    m_rdy = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      logic [7:0] kv;
      kv = 8'(16 * n);
      send_one(8'h10, kv);
    end
    repeat (3) @(negedge clk);
    chk("bp_stall", s_rdy, 0);
    chk("bp_vld", m_vld, 1);
    @(posedge clk);
    #1;
    m_rdy = 1'b1;
    @(posedge clk);
    #1;
    m_rdy = 1'b0;
    @(negedge clk);
    chk("bp_push", s_rdy, 1);
    chk("bp_cnt", sb.size(), 4);
    @(posedge clk);
    #1;
    drain();

    done = 0;
    fork
      begin
        for (int v = 0; v < 200; v++) begin
          for (int i = 0; i < 4; i++) begin
            qa[i] = 8'($urandom);
            ka[i] = 8'($urandom);
          end
          send_vec(qa, ka, 2);
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          m_rdy = 1'($urandom_range(0, 1));
        end
      end
    join
    drain();

    m_rdy = 1'b0;
    send_uni(8'h40, 8'h40);
    send_one(8'h10, 8'h20);
    for (int i = 0; i < 3; i++) begin
      send_beat(8'h40, 0);
      send_beat(8'h40, 0);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    sb.delete();
    @(negedge clk);
    chk("mid_rst_vld", m_vld, 0);
    chk("mid_rst_srdy", s_rdy, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_rdy = 1'b1;
    send_uni(8'h40, 8'h40);
    drain();

    $display("CHECKS %0d ERRORS %0d", nchecks, nerr);
    $finish;
  end

endmodule

// File: doc/attn_score_mac.md
# attn_score_mac

Parametrised query·key dot-product engine for the credit-pipelined attention datapath. It consumes a serial stream of interleaved q/k feature bytes over a vld/rdy slave port and accumulates NFEAT signed products. It then scales and saturates each score and queues it in an output FIFO drained through a vld/rdy master port. It replaces the fixed 4-feature, unscaled, non-backpressured MAC stage that feeds the e^x unit.

## Interface
- DW, 8: element width; q, k and score are signed Q0.(DW-1).
- NFEAT, 4: features per score (≥1); one feature is one q/k pair.
- SHIFT, 1: extra arithmetic right shift applied to the accumulated score (0..DW).
- FIFO_DEPTH, 4: output queue entries; power of two, ≥2.
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- s_data  in  DW  stream element; even beats are q, odd beats are k.
- s_vld  in  1  s_data valid.
- s_rdy  out  1  engine accepts s_data this cycle.
- m_data  out  DW  saturated score at FIFO head.
- m_sat  out  1  head score was saturated.
- m_vld  out  1  FIFO non-empty.
- m_rdy  in  1  consumer accepts head this cycle.

## Operation
- A beat transfers on any edge with s_vld & s_rdy; m_data is popped on any edge with m_vld & m_rdy.
- States:
  - GET_Q: s_rdy=1. On transfer, latch q into q_reg and go to GET_K.
  - GET_K: s_rdy=1. On transfer, acc <= acc + q_reg*s_data (full-precision signed product, 2·DW bits) and pair_cnt++. If pair_cnt was NFEAT-1, go to FINISH; else go to GET_Q.
  - FINISH: s_rdy=0. Push {sat, score} when the FIFO is not full, or is full with a pop on the same edge. On push, clear acc and pair_cnt and go to GET_Q; otherwise hold.
- Accumulator width ACCW = 2·DW + clog2(NFEAT) + 1; it never wraps.
- Scaling: t = acc >>> (DW-1+SHIFT), arithmetic shift, rounding toward −∞.
- Saturation:
  - t > 2^(DW-1)-1 gives score = 2^(DW-1)-1 and sat=1.
  - t < −2^(DW-1) gives score = −2^(DW-1) and sat=1.
  - Otherwise score = t[DW-1:0] and sat=0.
- FIFO:
  - Circular; FIFO_DEPTH entries of DW+1 bits; rd/wr pointers wrap modulo FIFO_DEPTH.
  - count ranges 0..FIFO_DEPTH.
  - Push and pop on the same edge leave count unchanged, both when full and when non-empty.
  - Pop when empty and push when full without a pop are impossible by construction.
- Output drive:
  - m_vld = (count != 0).
  - m_data and m_sat come from the head entry.
  - When empty, m_data and m_sat are driven 0.
- s_vld while s_rdy=0 is ignored and nothing is consumed.
- A held s_vld with no change in s_data is consumed once per transfer edge; the stream is beat-counted, not edge-detected.

## Timing
- Reset values:
  - State GET_Q; s_rdy=1.
  - acc=0, pair_cnt=0, q_reg=0.
  - FIFO empty: m_vld=0, m_data=0, m_sat=0.
- Reset mid-vector discards the partial accumulation. Reset with a non-empty FIFO discards all queued scores.
- Latency:
  - Final k transfer at edge E gives FINISH during E..E+1.
  - The push occurs at edge E+1.
  - m_vld=1 with the new score from edge E+1, i.e. two edges after the final k beat.
- Throughput with the consumer always ready: one score per 2·NFEAT+1 cycles. FINISH is the only bubble.
- Backpressure: with the FIFO full and m_rdy=0, the engine holds in FINISH with s_rdy=0 indefinitely. The score is pushed on the first edge with m_rdy=1.
- m_data and m_sat are stable while m_vld=1 and m_rdy=0.
- m_vld never drops without a pop.

## Test plan
Default parameters (DW=8, NFEAT=4, SHIFT=1, FIFO_DEPTH=4); m_rdy=1 unless stated.
- 4 pairs of q=0x40, k=0x40 -> acc=16384, m_data=0x40, m_sat=0. m_vld rises 2 edges after the last k. The next q is accepted 1 cycle after FINISH.
- 4 pairs of q=0x7F, k=0x7F -> t=252, m_data=0x7F, m_sat=1. 4 pairs of q=0x80, k=0x7F -> t=−254, m_data=0x80, m_sat=1.
- Floor rounding: pairs (0x01,0xFF),(0,0),(0,0),(0,0) -> acc=−1, m_data=0xFF, m_sat=0. Pairs (0x01,0x01),(0,0)×3 -> m_data=0x00.
- Backpressure: m_rdy=0 and 5 vectors giving scores 1..5:
  - Four are queued; the 5th stalls in FINISH with s_rdy=0.
  - Raising m_rdy pops 1,2,3,4,5 in order.
  - Score 5 is pushed on the same edge that pops 1, and count stays 4.
- Random s_vld gaps and m_rdy toggling over 200 vectors -> scores match the reference model. There are no beats lost or duplicated, and m_data is stable whenever m_vld & !m_rdy.
- Reset asserted after 3 pairs with 2 scores queued -> m_vld=0, s_rdy=1. The next full vector of 4×(0x40,0x40) yields exactly 0x40.
